// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 byte transmitter driving open-drain OE pins.
// Optional: define PS2_TX_RETRY_EN to retry a failed byte once before ERROR.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       CLK100MHZ,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);

  localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    bit_q, bit_d;
  logic [10:0]   frame_q, frame_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;
  logic clk_fall, accept, to_hit, nack, fail, retry;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false fall
  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= PS2_CLK_IN;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= PS2_DATA_IN;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_s2_q;
  assign accept   = (state_q == S_IDLE) & TX_VALID;
  assign to_hit   = ((state_q == S_SEND) | (state_q == S_ACK) |
                     (state_q == S_WAIT)) & (to_q == TO_LAST);
  assign nack     = (state_q == S_ACK) & clk_fall & dat_s2_q & ~to_hit;
  assign fail     = to_hit | nack;

`ifdef PS2_TX_RETRY_EN
  logic [7:0] data_q, data_d;
  logic       retry_q, retry_d;

  assign retry = fail & ~retry_q;

  always_comb begin
    data_d  = data_q;
    retry_d = retry_q;
    if (accept) begin
      data_d  = TX_DATA;
      retry_d = 1'b0;
    end else if (retry) begin
      retry_d = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      data_q  <= '0;
      retry_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      retry_q <= retry_d;
    end
  end
`else
  assign retry = 1'b0;
`endif

  always_ff @(posedge CLK100MHZ or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      inh_q   <= '0;
      to_q    <= '0;
      bit_q   <= '0;
      frame_q <= '1;
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      to_q    <= to_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (TX_VALID) state_d = S_INHIBIT;
      S_INHIBIT: if (inh_q == INH_LAST) state_d = S_REQ;
      S_REQ:     state_d = S_SEND;
      S_SEND:    if (clk_fall && bit_q == 4'd9) state_d = S_ACK;
      S_ACK:     if (clk_fall) state_d = dat_s2_q ? S_IDLE : S_WAIT;
      S_WAIT:    if (clk_s2_q && dat_s2_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (fail) state_d = retry ? S_INHIBIT : S_IDLE;
  end

  // Frame is {stop, parity, data, start}; bit 0 is what the line carries now
  always_comb begin
    inh_d   = '0;
    to_d    = '0;
    bit_d   = bit_q;
    frame_d = frame_q;
    unique case (state_q)
      S_IDLE: begin
        if (TX_VALID) frame_d = {1'b1, ~^TX_DATA, TX_DATA, 1'b0};
      end
      S_INHIBIT: inh_d = inh_q + IW'(1);
      S_REQ:     bit_d = '0;
      S_SEND: begin
        to_d = to_q + TW'(1);
        if (clk_fall) begin
          frame_d = {1'b1, frame_q[10:1]};
          bit_d   = bit_q + 4'd1;
        end
      end
      S_ACK:   to_d = to_q + TW'(1);
      S_WAIT:  to_d = to_q + TW'(1);
      default: ;
    endcase
`ifdef PS2_TX_RETRY_EN
    if (retry) frame_d = {1'b1, ~^data_q, data_q, 1'b0};
`endif
  end

  always_comb begin
    TX_READY    = 1'b0;
    BUSY        = 1'b1;
    PS2_CLK_OE  = 1'b0;
    PS2_DATA_OE = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        TX_READY = 1'b1;
        BUSY     = 1'b0;
      end
      S_INHIBIT: PS2_CLK_OE = 1'b1;
      S_REQ: begin
        PS2_CLK_OE  = 1'b1;
        PS2_DATA_OE = ~frame_q[0];
      end
      S_SEND:  PS2_DATA_OE = ~frame_q[0];
      default: ;
    endcase
    DONE  = (state_q == S_WAIT) & clk_s2_q & dat_s2_q & ~to_hit;
    ERROR = fail & ~retry;
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed vectors plus hand sequences for ps2_host_tx.
// A simple device model clocks frames, samples on rises and drives the ACK.
module tb_ps2_host_tx;

  localparam int INH = 100;
  localparam int TO  = 3000;
  localparam int H   = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, clk_oe, data_oe, busy, done, error;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk, ps2_data;

  always #5 clk = ~clk;

  assign ps2_clk  = dev_clk & ~clk_oe;
  assign ps2_data = dev_data & ~data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK100MHZ  (clk),
    .RESET      (rst),
    .TX_DATA    (tx_data),
    .TX_VALID   (tx_valid),
    .TX_READY   (tx_ready),
    .PS2_CLK_IN (ps2_clk),
    .PS2_DATA_IN(ps2_data),
    .PS2_CLK_OE (clk_oe),
    .PS2_DATA_OE(data_oe),
    .BUSY       (busy),
    .DONE       (done),
    .ERROR      (error)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int rdy_bad = 0, done_rdy_bad = 0;
  int err_cyc = 0, fall11_cyc = 0;
  int fall_no = 0;
  int inh_len, inh_doe;
  logic [9:0] cap_bits;
  logic req_ok, start_ok;
  logic abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (done && error) both_cnt++;
    if (busy == tx_ready) rdy_bad++;
    if (done && tx_ready) done_rdy_bad++;
  end

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic dev_frame(input logic ack_low);
    int n;
    cap_bits = '0;
    inh_len  = 0;
    inh_doe  = 0;
    req_ok   = 1'b0;
    start_ok = 1'b0;
    n = 0;
    while (!clk_oe && n < 2000 && !abort) begin
      @(negedge clk);
      n++;
    end
    while (clk_oe && inh_len < 2000 && !abort) begin
      req_ok = data_oe;
      if (data_oe) inh_doe++;
      inh_len++;
      @(negedge clk);
    end
    start_ok = data_oe && !ps2_data;
    for (int i = 1; i <= 11 && !abort; i++) begin
      repeat (H) @(negedge clk);
      if (abort) break;
      if (i == 11 && ack_low) dev_data = 1'b0;
      dev_clk = 1'b0;
      fall_no = i;
      if (i == 11) fall11_cyc = cyc;
      repeat (H) @(negedge clk);
      if (abort) break;
      if (i <= 10) cap_bits[i-1] = ps2_data;
      dev_clk = 1'b1;
    end
    repeat (H) @(negedge clk);
    dev_data = 1'b1;
    dev_clk  = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, e0, n, lat, exp_n;

    // Line samples per rise 1..10: {stop, parity, D7..D0}, odd parity
    vecs[0] = '{data: 8'hED, bits: 10'h3ED};
    vecs[1] = '{data: 8'h01, bits: 10'h201};
    vecs[2] = '{data: 8'h00, bits: 10'h300};
    vecs[3] = '{data: 8'hF4, bits: 10'h2F4};
    vecs[4] = '{data: 8'hFF, bits: 10'h3FF};
    vecs[5] = '{data: 8'hAA, bits: 10'h3AA};

    rst      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {tx_ready, busy, clk_oe, data_oe, done, error},
          6'b100000);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_outputs", {tx_ready, busy, clk_oe, data_oe}, 4'b1000);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      check("ready_before_send", tx_ready, 1);
      send_byte(vecs[i].data);
      dev_frame(1'b1);
      repeat (10) @(negedge clk);
      check("inhibit_len", inh_len, INH + 1);
      check("data_oe_only_in_req", inh_doe, 1);
      check("req_both_oe", req_ok, 1);
      check("start_bit", start_ok, 1);
      check("frame_bits", cap_bits, vecs[i].bits);
      check("done_once", done_cnt - d0, 1);
      check("no_error", err_cnt - e0, 0);
      check("idle_after", {busy, tx_ready, clk_oe, data_oe}, 4'b0100);
    end

    // TX_VALID while busy must not disturb the frame on the line
    d0 = done_cnt;
    send_byte(8'hED);
    fork
      dev_frame(1'b1);
      begin
        repeat (40) @(negedge clk);
        check("busy_during_frame", busy, 1);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("busy_ignore_bits", cap_bits, 10'h3ED);
    check("busy_ignore_done", done_cnt - d0, 1);
    repeat (50) @(negedge clk);
    check("busy_ignore_no_frame", {busy, clk_oe}, 2'b00);

    // Device leaves data high on fall 11: missing ACK
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h55);
    dev_frame(1'b0);
`ifdef PS2_TX_RETRY_EN
    check("retry_first_silent", err_cnt - e0, 0);
    check("retry_first_bits", cap_bits, 10'h355);
    dev_frame(1'b0);
`endif
    repeat (10) @(negedge clk);
    lat = err_cyc - fall11_cyc;
    check("nack_bits", cap_bits, 10'h355);
    check("nack_error_once", err_cnt - e0, 1);
    check("nack_no_done", done_cnt - d0, 0);
    check("nack_err_latency", (lat >= 1 && lat <= 4), 1);
    check("nack_idle", {busy, tx_ready, clk_oe, data_oe}, 4'b0100);

    // Device never clocks after release
    d0 = done_cnt;
    e0 = err_cnt;
    send_byte(8'h12);
    n = 0;
    while (clk_oe && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n = 1;
    while (!error && n < 2 * TO + INH + 100) begin
      @(negedge clk);
      n++;
    end
`ifdef PS2_TX_RETRY_EN
    exp_n = 2 * TO + INH + 1;
`else
    exp_n = TO;
`endif
    check("timeout_cycles", n, exp_n);
    @(negedge clk);
    check("timeout_oe_released", {clk_oe, data_oe, tx_ready}, 3'b001);
    check("timeout_error_once", err_cnt - e0, 1);
    check("timeout_no_done", done_cnt - d0, 0);

    // Asynchronous reset during data bit 4
    repeat (5) @(negedge clk);
    fall_no = 0;
    abort   = 1'b0;
    send_byte(8'h2C);
    fork
      dev_frame(1'b1);
      begin
        n = 0;
        while (fall_no < 5 && n < 3000) begin
          @(negedge clk);
          n++;
        end
        repeat (6) @(negedge clk);
        check("bit4_driven_low", data_oe, 1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_oe", {clk_oe, data_oe}, 2'b00);
        check("rst_async_ready", {tx_ready, busy}, 2'b10);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    repeat (10) @(negedge clk);

    d0 = done_cnt;
    e0 = err_cnt;
    check("ready_after_rst", tx_ready, 1);
    send_byte(8'hF4);
    dev_frame(1'b1);
    repeat (10) @(negedge clk);
    check("post_rst_bits", cap_bits, 10'h2F4);
    check("post_rst_done", done_cnt - d0, 1);
    check("post_rst_no_err", err_cnt - e0, 0);

    check("done_error_overlap", both_cnt, 0);
    check("busy_vs_ready", rdy_bad, 0);
    check("ready_in_done_cycle", done_rdy_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
